// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side packer: byte width, packer state
// encoding and the byte-keep mask helper.
package fifo_pkg;

  localparam int BYTE_W  = 8;
  localparam int MAX_BPW = 8;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    EMIT
  } rdpk_state_t;

  // Mask with the low `lanes` bits set; lanes == MAX_BPW gives all ones.
  function automatic logic [MAX_BPW-1:0] keep_mask(input int unsigned lanes);
    logic [MAX_BPW:0] one_hot;
    one_hot = (MAX_BPW + 1)'(1) << lanes;
    return MAX_BPW'(one_hot - 1'b1);
  endfunction

endpackage

// File: rtl/fifo_rd_out_queue.sv
// Two-entry valid/ready output queue for the read-side packer; entry 0 is
// always the head, and occupancy is exported for slot reservation.
module fifo_rd_out_queue #(
  parameter int W = 8
) (
  input  logic         rd_clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic [1:0]   occ
);

  logic [W-1:0] ent0;
  logic [W-1:0] ent1;
  logic         pop;
  logic         do_push;

  assign valid   = (occ != 2'd0);
  assign pop     = valid && ready;
  assign do_push = push && ((occ != 2'd2) || pop);
  assign data    = valid ? ent0 : '0;

  // NOTE: both entries are reset so a drained queue presents zeros, not stale words.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      occ  <= 2'd0;
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      unique case ({do_push, pop})
        2'b10: begin
          if (occ == 2'd0) ent0 <= push_data;
          else             ent1 <= push_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            ent0 <= push_data;
          end else begin
            ent0 <= ent1;
            ent1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Packs the FIFO read byte stream into little-endian words with keep/last.
// Optional FIFO_RD_PACKER_STATS_EN adds a 16-bit accepted-word counter.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter  int BYTES_PER_WORD = 4,
  localparam int DATA_W         = BYTE_W * BYTES_PER_WORD
) (
  input  logic                      rd_clk,
  input  logic                      rst_n,
  output logic                      fifo_rd,
  input  logic [BYTE_W-1:0]         fifo_rdata,
  input  logic                      fifo_valid,
  input  logic                      fifo_empty,
  input  logic                      fifo_underflow,
  input  logic                      flush,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_W-1:0]         m_data,
  output logic [BYTES_PER_WORD-1:0] m_keep,
  output logic                      m_last,
`ifdef FIFO_RD_PACKER_STATS_EN
  output logic [15:0]               word_cnt,
`endif
  output logic                      err
);

  localparam int             LW        = $clog2(BYTES_PER_WORD);
  localparam logic [LW-1:0]  LAST_LANE = LW'(BYTES_PER_WORD - 1);
  localparam int             QW        = DATA_W + BYTES_PER_WORD + 1;

  rdpk_state_t               state;
  rdpk_state_t               state_nxt;
  logic [LW-1:0]             iss_lane;
  logic [LW-1:0]             cap_lane;
  logic                      rd_q;
  logic                      cmp_q;
  logic [1:0]                occ;
  logic [1:0]                resv;
  logic [DATA_W-1:0]         shreg;
  logic [DATA_W-1:0]         shreg_upd;
  logic [DATA_W-1:0]         part_data;
  logic [BYTES_PER_WORD-1:0] part_keep;
  logic                      cap_push;
  logic                      emit_push;
  logic [QW-1:0]             q_push_data;
  logic [QW-1:0]             q_data;

  // A completing read is only issued if its word already owns a queue slot.
  assign resv    = occ + {1'b0, cmp_q};
  assign fifo_rd = rst_n && !fifo_empty && (state == RUN) &&
                   ((iss_lane != LAST_LANE) || (resv < 2'd2));

  assign cap_push  = fifo_valid && (cap_lane == LAST_LANE);
  assign emit_push = (state == EMIT) && (occ != 2'd2);
  assign part_keep = BYTES_PER_WORD'(keep_mask(32'(cap_lane)));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    shreg_upd = shreg;
    part_data = '0;
    if (fifo_valid) shreg_upd[cap_lane*BYTE_W +: BYTE_W] = fifo_rdata;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (part_keep[i]) part_data[i*BYTE_W +: BYTE_W] = shreg[i*BYTE_W +: BYTE_W];
    end
  end

  assign q_push_data = emit_push ? {1'b1, part_keep, part_data}
                                 : {1'b0, {BYTES_PER_WORD{1'b1}}, shreg_upd};

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (flush) state_nxt = DRAIN;
      DRAIN:   if (!rd_q) state_nxt = (cap_lane == '0) ? RUN : EMIT;
      EMIT:    if (occ != 2'd2) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      iss_lane <= '0;
      cap_lane <= '0;
      rd_q     <= 1'b0;
      cmp_q    <= 1'b0;
      shreg    <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      rd_q  <= fifo_rd;
      cmp_q <= fifo_rd && (iss_lane == LAST_LANE);
      shreg <= shreg_upd;
      if (fifo_underflow || (fifo_valid && !rd_q)) err <= 1'b1;

      if (emit_push) begin
        iss_lane <= '0;
        cap_lane <= '0;
      end else begin
        if (fifo_rd)
          iss_lane <= (iss_lane == LAST_LANE) ? '0 : iss_lane + LW'(1);
        if (fifo_valid)
          cap_lane <= (cap_lane == LAST_LANE) ? '0 : cap_lane + LW'(1);
      end
    end
  end

  fifo_rd_out_queue #(
    .W (QW)
  ) u_out_queue (
    .rd_clk    (rd_clk),
    .rst_n     (rst_n),
    .push      (cap_push || emit_push),
    .push_data (q_push_data),
    .ready     (m_ready),
    .valid     (m_valid),
    .data      (q_data),
    .occ       (occ)
  );

  assign m_last = q_data[QW-1];
  assign m_keep = q_data[QW-2 -: BYTES_PER_WORD];
  assign m_data = q_data[DATA_W-1:0];

`ifdef FIFO_RD_PACKER_STATS_EN
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n)                 word_cnt <= 16'd0;
    else if (m_valid && m_ready) word_cnt <= word_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: a byte-queue FIFO model feeds the DUT and a
// word-level scoreboard built from the pushed byte order checks every output.
module tb_fifo_rd_packer;
  import fifo_pkg::*;

  localparam int BPW = 4;
  localparam int DW  = BYTE_W * BPW;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [BPW-1:0] keep;
    logic           last;
  } word_t;

  typedef struct {
    int             nb;
    logic [7:0]     base;
    logic [DW-1:0]  data;
    logic [BPW-1:0] keep;
    logic           last;
    int             words;
  } vec_t;

  logic           rd_clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           fifo_rd;
  logic [7:0]     fifo_rdata = 8'h00;
  logic           fifo_valid = 1'b0;
  logic           fifo_empty = 1'b1;
  logic           fifo_underflow = 1'b0;
  logic           flush = 1'b0;
  logic           m_valid;
  logic           m_ready = 1'b0;
  logic [DW-1:0]  m_data;
  logic [BPW-1:0] m_keep;
  logic           m_last;
  logic           err;
`ifdef FIFO_RD_PACKER_STATS_EN
  logic [15:0]    word_cnt;
`endif

  logic [7:0] fifo_q[$];
  logic [7:0] pend[$];
  word_t      exp_q[$];
  vec_t       vecs[5];

  int    n_checks = 0;
  int    n_pass = 0;
  int    cyc = 0;
  int    words_got = 0;
  int    words_since_rst = 0;
  logic  s_rd, s_mv, s_err;
  int    s_cyc;
  word_t s_word = '0;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_packer #(.BYTES_PER_WORD(BPW)) dut (
    .rd_clk         (rd_clk),
    .rst_n          (rst_n),
    .fifo_rd        (fifo_rd),
    .fifo_rdata     (fifo_rdata),
    .fifo_valid     (fifo_valid),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .flush          (flush),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_keep         (m_keep),
    .m_last         (m_last),
`ifdef FIFO_RD_PACKER_STATS_EN
    .word_cnt       (word_cnt),
`endif
    .err            (err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
  endtask

  // Reference: bytes pack in arrival order, first byte in the low lane.
  task automatic model_emit(input logic last_w);
    word_t w;
    w = '0;
    w.last = last_w;
    for (int i = 0; i < pend.size(); i++) begin
      w.data[i*8 +: 8] = pend[i];
      w.keep[i]        = 1'b1;
    end
    pend.delete();
    exp_q.push_back(w);
  endtask

  task automatic fifo_push(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_empty = 1'b0;
    pend.push_back(b);
    if (pend.size() == BPW) model_emit(1'b0);
  endtask

  task automatic model_flush();
    if (pend.size() > 0) model_emit(1'b1);
  endtask

  task automatic tick();
    logic rd_now;
    @(negedge rd_clk);
    rd_now = fifo_rd;
    s_rd   = fifo_rd;
    s_mv   = m_valid;
    s_err  = err;
    s_cyc  = cyc;
    if (fifo_rd) check("rd_when_empty", 64'(fifo_empty), 64'd0);
    if (m_valid && m_ready) begin
      s_word = {m_data, m_keep, m_last};
      words_got++;
      words_since_rst++;
      check("word_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("word", 64'(s_word), 64'(exp_q.pop_front()));
    end
    @(posedge rd_clk);
    #1;
    cyc++;
    if (rd_now && fifo_q.size() > 0) begin
      fifo_rdata = fifo_q.pop_front();
      fifo_valid = 1'b1;
    end else begin
      fifo_valid = 1'b0;
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic clear_models();
    fifo_q.delete();
    pend.delete();
    exp_q.delete();
    fifo_valid      = 1'b0;
    fifo_empty      = 1'b1;
    words_since_rst = 0;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    flush          = 1'b0;
    fifo_underflow = 1'b0;
    clear_models();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_n, first_rd, last_rd, first_mv, w0, fl_cyc, mv_cyc;

    vecs[0] = '{1, 8'h11, 32'h0000_0011, 4'h1, 1'b1, 1};
    vecs[1] = '{2, 8'h21, 32'h0000_2221, 4'h3, 1'b1, 1};
    vecs[2] = '{3, 8'h31, 32'h0033_3231, 4'h7, 1'b1, 1};
    vecs[3] = '{4, 8'h41, 32'h4443_4241, 4'hF, 1'b0, 1};
    vecs[4] = '{5, 8'h51, 32'h0000_0055, 4'h1, 1'b1, 2};

    // Reset state, with the FIFO claiming data so the read strobe is exercised.
    fifo_empty = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_fifo_rd", 64'(fifo_rd), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data",  64'(m_data),  64'd0);
    check("rst_m_keep",  64'(m_keep),  64'd0);
    check("rst_m_last",  64'(m_last),  64'd0);
    check("rst_err",     64'(err),     64'd0);
    fifo_empty = 1'b1;
    repeat (2) tick();
    rst_n   = 1'b1;
    m_ready = 1'b1;
    tick();

    // Two full words streaming at one byte per cycle.
    rd_n = 0; first_rd = -1; last_rd = -1; first_mv = -1; w0 = words_got;
    for (int i = 1; i <= 8; i++) fifo_push(8'(i));
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_rd) begin
        if (first_rd < 0) first_rd = s_cyc;
        last_rd = s_cyc;
        rd_n++;
      end
      if (s_mv && first_mv < 0) first_mv = s_cyc;
    end
    check("stream_reads", 64'(rd_n), 64'd8);
    check("stream_consecutive", 64'(last_rd - first_rd), 64'd7);
    check("first_valid_latency", 64'(first_mv - first_rd), 64'(BPW + 1));
    check("stream_words", 64'(words_got - w0), 64'd2);

    // Asynchronous reset while the second word is being read.
    rd_n = 0;
    for (int i = 1; i <= 8; i++) fifo_push(8'(i));
    for (int i = 0; i < 20 && rd_n < 6; i++) begin
      tick();
      if (s_rd) rd_n++;
    end
    check("midreset_reads", 64'(rd_n), 64'd6);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_fifo_rd", 64'(fifo_rd), 64'd0);
    check("midreset_m_valid", 64'(m_valid), 64'd0);
    check("midreset_m_data",  64'(m_data),  64'd0);
    check("midreset_m_keep",  64'(m_keep),  64'd0);
    check("midreset_m_last",  64'(m_last),  64'd0);
    check("midreset_err",     64'(err),     64'd0);
    clear_models();
    w0 = words_got;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("midreset_no_word", 64'(words_got - w0), 64'd0);
    check("midreset_err_after", 64'(s_err), 64'd0);

    // Backpressure: two words absorbed, reads stall at the next completing lane.
    m_ready = 1'b0; rd_n = 0; w0 = words_got;
    for (int i = 0; i < 16; i++) fifo_push(8'h10 + 8'(i));
    for (int i = 0; i < 30; i++) begin
      tick();
      if (s_rd) rd_n++;
    end
    check("bp_reads", 64'(rd_n), 64'(2 * BPW + BPW - 1));
    check("bp_stalled", 64'(s_rd), 64'd0);
    check("bp_valid_held", 64'(s_mv), 64'd1);
    m_ready = 1'b1;
    for (int i = 0; i < 80 && (words_got - w0) < 4; i++) tick();
    check("bp_words", 64'(words_got - w0), 64'd4);
    check("bp_all_delivered", 64'(exp_q.size()), 64'd0);

    // Table of byte counts followed by a flush.
    for (int v = 0; v < 5; v++) begin
      w0 = words_got;
      for (int b = 0; b < vecs[v].nb; b++) fifo_push(vecs[v].base + 8'(b));
      repeat (12) tick();
      flush = 1'b1;
      model_flush();
      tick();
      flush = 1'b0;
      repeat (8) tick();
      check($sformatf("vec%0d_words", v), 64'(words_got - w0), 64'(vecs[v].words));
      check($sformatf("vec%0d_last_word", v), 64'(s_word),
            64'({vecs[v].data, vecs[v].keep, vecs[v].last}));
    end

    // Partial word AA BB CC closed by flush.
    for (int i = 0; i < 3; i++) fifo_push(8'hAA + 8'(i * 17));
    repeat (10) tick();
    flush = 1'b1;
    model_flush();
    fl_cyc = cyc;
    tick();
    flush = 1'b0;
    mv_cyc = -1;
    for (int i = 0; i < 10 && mv_cyc < 0; i++) begin
      tick();
      if (s_mv) mv_cyc = s_cyc;
    end
    check("flush_latency_ge2", 64'((mv_cyc - fl_cyc) >= 2), 64'd1);
    check("flush_word", 64'(s_word), 64'({32'h00CC_BBAA, 4'h7, 1'b1}));

    // Flush on a word boundary: one DRAIN cycle, no word, reads resume.
    w0 = words_got;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    fifo_push(8'h5A);
    tick();
    check("drain_no_read", 64'(s_rd), 64'd0);
    tick();
    check("run_read_resumes", 64'(s_rd), 64'd1);
    repeat (6) tick();
    check("boundary_no_word", 64'(words_got - w0), 64'd0);
    flush = 1'b1;
    model_flush();
    tick();
    flush = 1'b0;
    repeat (8) tick();
    check("single_byte_word", 64'(s_word), 64'({32'h0000_005A, 4'h1, 1'b1}));

    // Random arrivals and random downstream readiness.
    for (int i = 0; i < 400; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) fifo_push(8'($urandom));
      tick();
    end
    m_ready = 1'b1;
    for (int i = 0; i < 200 && fifo_q.size() != 0; i++) tick();
    repeat (8) tick();
    flush = 1'b1;
    model_flush();
    tick();
    flush = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("random_drained", 64'(exp_q.size()), 64'd0);
    check("random_fifo_empty", 64'(fifo_q.size()), 64'd0);
    check("random_no_err", 64'(s_err), 64'd0);

`ifdef FIFO_RD_PACKER_STATS_EN
    check("word_cnt", 64'(word_cnt), 64'(16'(words_since_rst)));
`endif

    // Sticky error sources.
    fifo_underflow = 1'b1;
    tick();
    fifo_underflow = 1'b0;
    tick();
    check("err_underflow", 64'(s_err), 64'd1);
    repeat (5) tick();
    check("err_sticky", 64'(s_err), 64'd1);
    do_reset();
    check("err_cleared", 64'(err), 64'd0);
    fifo_valid = 1'b1;
    fifo_rdata = 8'hEE;
    tick();
    tick();
    check("err_spurious_valid", 64'(s_err), 64'd1);
    do_reset();
    check("err_reset", 64'(err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
